shift_add_mult_seq: RTL and testbench
=====================================

// Module: shift_add_mult_seq
// PURPOSE
// - Sequencer for the shifter datapath: runs an unsigned WIDTH x WIDTH multiply as shift-and-add, one bit per clock.
// - Returns a 2*WIDTH-bit product, e.g. a 4-bit operand giving an 8-bit Result.
// - Owns the start/busy/done handshake, iteration counter, shift strobes and product accumulator.
// - Sits between the issuing logic and the result consumer.
// PARAMETERS
// - WIDTH, default 4: operand width; product is 2*WIDTH bits; WIDTH >= 2.
// - CNT_W, default 3: iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
// - clk     in   1          rising-edge clock, single clock domain
// - rst_n   in   1          asynchronous, active-low reset
// - start   in   1          request; sampled only in IDLE
// - a       in   WIDTH      multiplicand, captured on accepted start
// - b       in   WIDTH      multiplier, captured on accepted start
// - busy    out  1          high while an operation is in progress
// - done    out  1          one-cycle pulse: result updated
// - result  out  2*WIDTH    product, held until next done
// - sh_en   out  1          shift strobe: high in every RUN cycle
// - sh_cnt  out  CNT_W      index of the current iteration, 0..WIDTH-1
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, result=0, sh_en=0, sh_cnt=0.
//   Internal mcand, mplr and acc also clear.
//   Asserting reset mid-operation aborts it; no done is produced.
// - FSM states: IDLE, RUN. All outputs are registered.
// - IDLE: start=1 at edge E0 -> RUN.
//   Load mcand={WIDTH'b0,a}, mplr=b, acc=0, sh_cnt=0, busy=1, sh_en=1.
// - RUN, each edge:
//   - if mplr[0]: acc <= acc + mcand (2*WIDTH-bit, cannot overflow).
//   - mcand <= mcand<<1; mplr <= mplr>>1; sh_cnt <= sh_cnt+1.
// - Finish edge: the edge that performs the last iteration.
//   - result <= final acc (including that edge's add); done <= 1.
//   - busy <= 0; sh_en <= 0; sh_cnt <= 0; state -> IDLE.
//   - Without early termination this is edge E(WIDTH).
// - done is high for exactly one cycle, the cycle after the finish edge.
//   busy is low in that cycle.
// - Latency: start accepted at E0 -> done high after E(WIDTH), i.e. WIDTH cycles.
//   Issue rate: one operation per WIDTH+1 cycles max.
// - start while busy=1 is ignored; it is not queued and has no effect.
// - start in the cycle done=1 is accepted (FSM is in IDLE). Back-to-back operations are legal.
// - result is not disturbed by a new start; it changes only on a finish edge.
// - a and b are don't-care except at the accepting edge.
// CONFIGURATION
// - EARLY_TERM_EN defined:
//   - the finish edge is the first RUN edge at which mplr>>1 == 0 (remaining multiplier bits zero).
//   - Latency = max(1, position of highest set bit of b + 1) cycles; b=0 -> done after E1.
//   - sh_en and sh_cnt stop at that edge.
// - EARLY_TERM_EN undefined: always exactly WIDTH iterations; latency fixed at WIDTH.
// TESTING (WIDTH=4)
// - Reset then idle: all outputs 0. Pulse rst_n=0 asynchronously mid-cycle -> outputs clear immediately.
// - a=15, b=15, start 1 cycle -> busy for 4 cycles, sh_cnt 0,1,2,3.
//   done pulses once; result=225 (8'hE1).
// - a=7, b=3 -> result=21, done 4 cycles after start without EARLY_TERM_EN; 2 cycles with it.
// - a=9, b=0 -> result=0, done after 4 cycles (1 cycle with EARLY_TERM_EN).
//   The previous result is held until that done.
// - start held high through an operation (a=5, b=6):
//   - extra starts while busy are ignored; result=30.
//   - a new op (a=2, b=2) accepted in the done cycle -> result=4 after 4 more cycles.
// - rst_n low at sh_cnt=2 of a 12*11 operation:
//   - no done, result=0.
//   - after release, start a=3, b=4 -> result=12.

Source files
------------

// File: rtl/shift_add_mult_if.sv
// Handshake/result bundle for the shift-and-add multiplier sequencer.
//   start  : request from issuer, sampled only while the sequencer is idle
//   a, b   : multiplicand / multiplier, captured on the accepting edge
//   busy   : operation in progress
//   done   : one-cycle pulse, result just updated
//   result : 2*WIDTH-bit product, held until the next done
//   sh_en  : shift strobe, high in every RUN cycle
//   sh_cnt : index of the current iteration
// Modports: master = issuing/consuming side, slave = sequencer.
interface shift_add_mult_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) ();
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               sh_en;
  logic [CNT_W-1:0]   sh_cnt;

  modport master (
    output start, a, b,
    input  busy, done, result, sh_en, sh_cnt
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, sh_en, sh_cnt
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier, shift-and-add, one multiplier bit per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any operation in flight
//   bus   : shift_add_mult_if.slave (start/a/b in; busy/done/result/sh_en/sh_cnt out)
// All outputs are registered. Without early termination an accepted start produces done
// exactly WIDTH cycles later.
// Optional feature: define EARLY_TERM_EN to finish as soon as the remaining multiplier bits
// are all zero (latency max(1, msb(b)+1)).
module shift_add_mult_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_add_mult_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sh_en_q, sh_en_d;
  logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;

  logic [PW-1:0]    acc_sum;
  logic             last_iter;

  // Accumulator including this edge's partial product; cannot overflow PW bits.
  assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

`ifdef EARLY_TERM_EN
  // Done once no set multiplier bits remain after this iteration.
  assign last_iter = ((mplr_q >> 1) == '0);
`else
  assign last_iter = (sh_cnt_q == CNT_W'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sh_en_q  <= 1'b0;
      sh_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sh_en_q  <= sh_en_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sh_en_d  = sh_en_q;
    sh_cnt_d = sh_cnt_q;
    unique case (state_q)
      StIdle: begin
        // start is ignored outside idle, so holding it high does not queue work.
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplr_d   = bus.b;
          acc_d    = '0;
          sh_cnt_d = '0;
          busy_d   = 1'b1;
          sh_en_d  = 1'b1;
        end
      end
      StRun: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        if (last_iter) begin
          result_d = acc_sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          sh_en_d  = 1'b0;
          sh_cnt_d = '0;
        end else begin
          sh_cnt_d = sh_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        sh_en_d = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.sh_en  = sh_en_q;
  assign bus.sh_cnt = sh_cnt_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Self-checking bench for shift_add_mult_seq (WIDTH=4). Stimulus pushes expected product and
// expected done cycle into a queue; a negedge monitor pops and checks on every done pulse.
// Build with +define+EARLY_TERM_EN to check the early-termination variant.
module tb_shift_add_mult_seq;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int n_cmp;
  int n_fail;

  typedef struct {
    logic [7:0]  res;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] prev_res;

  shift_add_mult_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_add_mult_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned lat(input logic [3:0] bb);
`ifdef EARLY_TERM_EN
    int unsigned l;
    l = 1;
    for (int i = 0; i < 4; i++) if (bb[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: done pulses against scoreboard; result must hold between done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_res = bus.result;
    end else if (bus.done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: result %0d with empty scoreboard (cyc=%0d)",
                 bus.result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.res) begin
          n_fail++;
          $display("FAIL result: got %0d, expected %0d", bus.result, e.res);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL done_cycle: got %0d, expected %0d", cyc, e.cyc);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_in_done: got %0d, expected 0", bus.busy);
        end
      end
      prev_res = bus.result;
    end else begin
      n_cmp++;
      if (bus.result !== prev_res) begin
        n_fail++;
        $display("FAIL result_hold: got %0d, expected %0d", bus.result, prev_res);
      end
    end
  end

  // Issue one operation; start is dropped right after the accepting edge.
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 4'hx;
    bus.b     = 4'hx;
    if (push) begin
      e.res = 8'(ia) * 8'(ib);
      e.cyc = cyc + lat(ib);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_sh_en"},  32'(bus.sh_en),  32'd0);
    check({tag, "_sh_cnt"}, 32'(bus.sh_cnt), 32'd0);
  endtask

  initial begin
    exp_t e;
    int unsigned c0;
    int n;
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_res  = '0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("idle");

    // 15 x 15: busy / sh_en / sh_cnt sequence during RUN
    issue(4'd15, 4'd15, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run_busy",   32'(bus.busy),   32'd1);
      check("run_sh_en",  32'(bus.sh_en),  32'd1);
      check("run_sh_cnt", 32'(bus.sh_cnt), 32'(i));
    end
    wait_idle();
    check("idle_after_busy",   32'(bus.busy),  32'd0);
    check("idle_after_sh_en",  32'(bus.sh_en), 32'd0);

    issue(4'd7, 4'd3, 1'b1);
    wait_idle();
    issue(4'd9, 4'd0, 1'b1);
    wait_idle();

    // start held through a 5 x 6 operation; 2 x 2 accepted in the done cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'd6;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.a = 4'd2;
    bus.b = 4'd2;
    e.res = 8'd30;
    e.cyc = c0 + lat(4'd6);
    sb.push_back(e);
    e.res = 8'd4;
    e.cyc = c0 + lat(4'd6) + 1 + lat(4'd2);
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 20);
    check("held_start_done_seen", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    // Abort 12 x 11 with an asynchronous reset at sh_cnt=2
    issue(4'd12, 4'd11, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sh_cnt !== 3'd2 && n < 10);
    check("abort_reach_cnt2", 32'(bus.sh_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_no_pending", 32'(sb.size()), 32'd0);

    issue(4'd3, 4'd4, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
